// File: rtl/app_div_unsigned8by6_seq.sv
// app_div_unsigned8by6_seq: iterative restoring unsigned divider.
// It produces one quotient bit per clock. Operands and results use valid/ready handshakes.
// Optional build macro DIV_EARLY_EXIT_EN: when dividend < divisor, the block skips the
// iterative loop and gives the result one cycle after the accept edge.
module app_div_unsigned8by6_seq #(
  parameter int WIDTH_N = 8,
  parameter int WIDTH_D = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg;
  // The dividend shifts out of the MSB while quotient bits shift in at the LSB.
  logic [WIDTH_N-1:0] dq_reg;
  logic [WIDTH_D-1:0] dvsr_reg;
  // One bit wider than the divisor so the shifted-in trial value always fits.
  logic [WIDTH_D:0]   rem_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH_D:0]   shifted;
  logic [WIDTH_D+1:0] trial;
  logic               trial_neg;
  logic [WIDTH_D:0]   rem_step;
  logic [WIDTH_N-1:0] dq_step;
  logic               accept;
  logic               early_exit;

  assign accept = in_valid && in_ready;

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (divisor != '0) && (dividend < WIDTH_N'(divisor));
`else
  assign early_exit = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
  always_comb begin
    shifted   = {rem_reg[WIDTH_D-1:0], dq_reg[WIDTH_N-1]};
    trial     = {1'b0, shifted} - {2'b00, dvsr_reg};
    trial_neg = trial[WIDTH_D+1];
    rem_step  = trial_neg ? shifted : trial[WIDTH_D:0];
    dq_step   = {dq_reg[WIDTH_N-2:0], ~trial_neg};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      dq_reg      <= '0;
      dvsr_reg    <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dq_reg   <= dividend;
            dvsr_reg <= divisor;
            rem_reg  <= '0;
            cnt_reg  <= CW'(WIDTH_N);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              // A zero divisor is resolved at once with the saturated result.
              state_reg   <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH_D-1:0];
              div_by_zero <= 1'b1;
            end else if (early_exit) begin
              state_reg   <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '0;
              remainder   <= dividend[WIDTH_D-1:0];
              div_by_zero <= 1'b0;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          dq_reg  <= dq_step;
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            // The last step's result goes straight to the output registers.
            state_reg   <= DONE;
            out_valid   <= 1'b1;
            quotient    <= dq_step;
            remainder   <= rem_step[WIDTH_D-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
